alien_hit_detector: RTL and testbench



---
 rtl/alien_hit_detector.sv | 213 +++++++++++++++++++++
 tb/tb_alien_hit_detector.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/alien_hit_detector.sv
// Bullet-versus-formation hit detector for a 5x10 alien grid: one request at a time, resolved by repeated subtraction.
// Optional ALIEN_SCORE_EN macro adds a saturating Score output.
module alien_hit_detector (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [8:0]  AliensRow,
    input  logic [9:0]  AliensCol,
    input  logic        Bullet_Valid,
    input  logic [8:0]  Bullet_Row,
    input  logic [9:0]  Bullet_Col,
    output logic        Bullet_Ready,
    input  logic        Wave_Reload,
    output logic        Hit_Valid,
    output logic        Hit,
    output logic [5:0]  Hit_Index,
    output logic [49:0] Aliens_Alive,
    output logic        All_Dead
`ifdef ALIEN_SCORE_EN
    ,
    output logic [15:0] Score
`endif
);

    localparam logic signed [10:0] COL_PITCH = 11'sd39;
    localparam logic signed [10:0] ROW_PITCH = 11'sd30;
    localparam logic signed [10:0] BOX_W     = 11'sd390;
    localparam logic signed [10:0] BOX_H     = 11'sd150;
    localparam logic signed [10:0] HIT_W     = 11'sd32;
    localparam logic signed [10:0] HIT_H     = 11'sd20;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        OFFSET = 3'd1,
        COLDIV = 3'd2,
        ROWDIV = 3'd3,
        CHECK  = 3'd4,
        RESP   = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [8:0]         brow_q, brow_d;
    logic [9:0]         bcol_q, bcol_d;
    logic [8:0]         arow_q, arow_d;
    logic [9:0]         acol_q, acol_d;
    logic signed [10:0] dx_q, dx_d;
    logic signed [10:0] dy_q, dy_d;
    logic [3:0]         col_q, col_d;
    logic [2:0]         row_q, row_d;
    logic               hit_q, hit_d;
    logic [5:0]         hit_index_q, hit_index_d;
    logic [49:0]        alive_q, alive_d;

    logic signed [10:0] dx_off;
    logic signed [10:0] dy_off;
    logic               out_of_range;
    logic [5:0]         cell_idx;
    logic               cell_hit;

    // Zero-extended positions keep the differences inside 11-bit signed range.
    assign dx_off = signed'({1'b0, bcol_q}) - signed'({1'b0, acol_q});
    assign dy_off = signed'({2'b00, brow_q}) - signed'({2'b00, arow_q});

    assign out_of_range = dx_off[10] || (dx_off >= BOX_W) ||
                          dy_off[10] || (dy_off >= BOX_H);

    assign cell_idx = ({3'b000, row_q} * 6'd10) + {2'b00, col_q};
    assign cell_hit = (dx_q < HIT_W) && (dy_q < HIT_H) && alive_q[cell_idx];

`ifdef ALIEN_SCORE_EN
    logic [15:0] score_q, score_d;

    function automatic logic [5:0] row_points(input logic [2:0] r);
        if (r == 3'd0)
            return 6'd30;
        else if (r <= 3'd2)
            return 6'd20;
        else
            return 6'd10;
    endfunction

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [5:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {11'd0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction
`endif

    always_comb begin
        state_d     = state_q;
        brow_d      = brow_q;
        bcol_d      = bcol_q;
        arow_d      = arow_q;
        acol_d      = acol_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        col_d       = col_q;
        row_d       = row_q;
        hit_d       = hit_q;
        hit_index_d = hit_index_q;
        alive_d     = alive_q;
`ifdef ALIEN_SCORE_EN
        score_d     = score_q;
`endif

        case (state_q)
            IDLE: begin
                if (Bullet_Valid) begin
                    brow_d  = Bullet_Row;
                    bcol_d  = Bullet_Col;
                    arow_d  = AliensRow;
                    acol_d  = AliensCol;
                    state_d = OFFSET;
                end
            end
            OFFSET: begin
                dx_d = dx_off;
                dy_d = dy_off;
                if (out_of_range) begin
                    hit_d   = 1'b0;
                    state_d = RESP;
                end else begin
                    col_d   = 4'd0;
                    row_d   = 3'd0;
                    state_d = COLDIV;
                end
            end
            COLDIV: begin
                if (dx_q >= COL_PITCH) begin
                    dx_d  = dx_q - COL_PITCH;
                    col_d = col_q + 4'd1;
                end else begin
                    state_d = ROWDIV;
                end
            end
            ROWDIV: begin
                if (dy_q >= ROW_PITCH) begin
                    dy_d  = dy_q - ROW_PITCH;
                    row_d = row_q + 3'd1;
                end else begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                hit_d       = cell_hit;
                hit_index_d = cell_idx;
                if (cell_hit)
                    alive_d[cell_idx] = 1'b0;
                state_d = RESP;
            end
            RESP: begin
`ifdef ALIEN_SCORE_EN
                if (hit_q)
                    score_d = sat_add(score_q, row_points(row_q));
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A reload wins over any kill cleared in the same cycle.
        if (Wave_Reload)
            alive_d = '1;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            brow_q      <= '0;
            bcol_q      <= '0;
            arow_q      <= '0;
            acol_q      <= '0;
            dx_q        <= '0;
            dy_q        <= '0;
            col_q       <= '0;
            row_q       <= '0;
            hit_q       <= 1'b0;
            hit_index_q <= '0;
            alive_q     <= '1;
        end else begin
            state_q     <= state_d;
            brow_q      <= brow_d;
            bcol_q      <= bcol_d;
            arow_q      <= arow_d;
            acol_q      <= acol_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            col_q       <= col_d;
            row_q       <= row_d;
            hit_q       <= hit_d;
            hit_index_q <= hit_index_d;
            alive_q     <= alive_d;
        end
    end

`ifdef ALIEN_SCORE_EN
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            score_q <= '0;
        else
            score_q <= score_d;
    end

    assign Score = score_q;
`endif

    assign Bullet_Ready = (state_q == IDLE);
    assign Hit_Valid    = (state_q == RESP);
    assign Hit          = hit_q;
    assign Hit_Index    = hit_index_q;
    assign Aliens_Alive = alive_q;
    assign All_Dead     = (alive_q == 50'd0);

endmodule

// File: tb/tb_alien_hit_detector.sv
// Directed bench for alien_hit_detector: table of single requests plus reload, sweep and reset sequences.
module tb_alien_hit_detector;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [8:0]  AliensRow;
    logic [9:0]  AliensCol;
    logic        Bullet_Valid;
    logic [8:0]  Bullet_Row;
    logic [9:0]  Bullet_Col;
    logic        Bullet_Ready;
    logic        Wave_Reload;
    logic        Hit_Valid;
    logic        Hit;
    logic [5:0]  Hit_Index;
    logic [49:0] Aliens_Alive;
    logic        All_Dead;
`ifdef ALIEN_SCORE_EN
    logic [15:0] Score;
`endif

    alien_hit_detector dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .AliensRow    (AliensRow),
        .AliensCol    (AliensCol),
        .Bullet_Valid (Bullet_Valid),
        .Bullet_Row   (Bullet_Row),
        .Bullet_Col   (Bullet_Col),
        .Bullet_Ready (Bullet_Ready),
        .Wave_Reload  (Wave_Reload),
        .Hit_Valid    (Hit_Valid),
        .Hit          (Hit),
        .Hit_Index    (Hit_Index),
        .Aliens_Alive (Aliens_Alive),
        .All_Dead     (All_Dead)
`ifdef ALIEN_SCORE_EN
        ,
        .Score        (Score)
`endif
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [8:0] arow;
        logic [9:0] acol;
        logic [8:0] brow;
        logic [9:0] bcol;
        int         lat;
        logic       hit;
        logic [5:0] idx;
    } vec_t;

    vec_t        vecs[14];
    int          n_pass = 0;
    int          n_total = 0;
    logic [49:0] alive_exp;
    int          score_exp;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic int pts(input int idx);
        int r;
        r = idx / 10;
        if (r == 0) return 30;
        else if (r <= 2) return 20;
        else return 10;
    endfunction

    // Formation inputs are scrambled after acceptance to prove they are sampled only once.
    task automatic send(input logic [8:0] arow, input logic [9:0] acol,
                        input logic [8:0] brow, input logic [9:0] bcol,
                        input int reload_at,
                        output int lat, output logic h, output logic [5:0] idx);
        @(negedge Clk);
        AliensRow    = arow;
        AliensCol    = acol;
        Bullet_Row   = brow;
        Bullet_Col   = bcol;
        Bullet_Valid = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Bullet_Valid = 1'b0;
        AliensRow    = ~arow;
        AliensCol    = acol + 10'd123;
        Bullet_Row   = '0;
        Bullet_Col   = '0;
        lat = 0;
        while (Hit_Valid !== 1'b1 && lat < 40) begin
            if (lat == reload_at)
                Wave_Reload = 1'b1;
            @(negedge Clk);
            Wave_Reload = 1'b0;
            lat++;
        end
        h   = Hit;
        idx = Hit_Index;
    endtask

    task automatic run_one(input string tag, input logic [8:0] arow, input logic [9:0] acol,
                           input logic [8:0] brow, input logic [9:0] bcol, input int reload_at,
                           input int exp_lat, input logic exp_hit, input logic [5:0] exp_idx);
        int         lat;
        logic       h;
        logic [5:0] idx;
        send(arow, acol, brow, bcol, reload_at, lat, h, idx);
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_hit"}, 64'(h), 64'(exp_hit));
        if (exp_hit) begin
            chk({tag, "_index"}, 64'(idx), 64'(exp_idx));
            alive_exp[exp_idx] = 1'b0;
            score_exp += pts(int'(exp_idx));
        end
        if (reload_at >= 0) begin
            alive_exp = '1;
            if (exp_hit && reload_at != exp_lat - 1)
                alive_exp[exp_idx] = 1'b0;
        end
        chk({tag, "_alive"}, 64'(Aliens_Alive), 64'(alive_exp));
        @(negedge Clk);
        chk({tag, "_strobe_one_cycle"}, 64'({Hit_Valid, Bullet_Ready}), 64'(2'b01));
    endtask

    initial begin
        int strobes;

        vecs[0]  = '{9'd0,  10'd10,  9'd5,   10'd5,   1,  1'b0, 6'd0};
        vecs[1]  = '{9'd0,  10'd10,  9'd35,  10'd93,  7,  1'b1, 6'd12};
        vecs[2]  = '{9'd0,  10'd10,  9'd35,  10'd93,  7,  1'b0, 6'd0};
        vecs[3]  = '{9'd0,  10'd10,  9'd5,   10'd162, 7,  1'b0, 6'd0};
        vecs[4]  = '{9'd0,  10'd10,  9'd5,   10'd400, 1,  1'b0, 6'd0};
        vecs[5]  = '{9'd0,  10'd10,  9'd5,   10'd399, 13, 1'b0, 6'd0};
        vecs[6]  = '{9'd0,  10'd10,  9'd139, 10'd392, 17, 1'b1, 6'd49};
        vecs[7]  = '{9'd0,  10'd10,  9'd150, 10'd20,  1,  1'b0, 6'd0};
        vecs[8]  = '{9'd0,  10'd10,  9'd5,   10'd42,  4,  1'b0, 6'd0};
        vecs[9]  = '{9'd0,  10'd10,  9'd20,  10'd15,  4,  1'b0, 6'd0};
        vecs[10] = '{9'd0,  10'd10,  9'd19,  10'd80,  5,  1'b1, 6'd1};
        vecs[11] = '{9'd0,  10'd10,  9'd60,  10'd205, 11, 1'b1, 6'd25};
        vecs[12] = '{9'd20, 10'd100, 9'd53,  10'd375, 12, 1'b1, 6'd17};
        vecs[13] = '{9'd20, 10'd100, 9'd10,  10'd150, 1,  1'b0, 6'd0};

        Reset        = 1'b1;
        AliensRow    = '0;
        AliensCol    = '0;
        Bullet_Valid = 1'b0;
        Bullet_Row   = '0;
        Bullet_Col   = '0;
        Wave_Reload  = 1'b0;
        alive_exp    = '1;
        score_exp    = 0;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        chk("reset_ready", 64'(Bullet_Ready), 64'd1);
        chk("reset_hit_valid", 64'(Hit_Valid), 64'd0);
        chk("reset_hit", 64'(Hit), 64'd0);
        chk("reset_hit_index", 64'(Hit_Index), 64'd0);
        chk("reset_alive", 64'(Aliens_Alive), 64'(alive_exp));
        chk("reset_all_dead", 64'(All_Dead), 64'd0);
`ifdef ALIEN_SCORE_EN
        chk("reset_score", 64'(Score), 64'd0);
`endif

        for (int i = 0; i < 14; i++)
            run_one($sformatf("vec%0d", i), vecs[i].arow, vecs[i].acol, vecs[i].brow,
                    vecs[i].bcol, -1, vecs[i].lat, vecs[i].hit, vecs[i].idx);
        chk("all_dead_partial", 64'(All_Dead), 64'd0);

        // Reload lands on the CHECK edge of a kill on alien 0.
        run_one("reload_check", 9'd0, 10'd10, 9'd5, 10'd15, 3, 4, 1'b1, 6'd0);
        // Reload during COLDIV must not disturb the running request.
        run_one("reload_coldiv", 9'd0, 10'd10, 9'd35, 10'd93, 1, 7, 1'b1, 6'd12);

        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 10; c++) begin
                run_one("sweep", 9'd0, 10'd10, 9'(r * 30 + 2), 10'(10 + c * 39 + 2), -1,
                        c + r + 4, alive_exp[r * 10 + c], 6'(r * 10 + c));
            end
        end
        chk("sweep_alive_zero", 64'(Aliens_Alive), 64'd0);
        chk("sweep_all_dead", 64'(All_Dead), 64'd1);
`ifdef ALIEN_SCORE_EN
        chk("sweep_score", 64'(Score), 64'(score_exp));
`endif

        // Reset while the column divider is running.
        @(negedge Clk);
        AliensRow    = 9'd0;
        AliensCol    = 10'd10;
        Bullet_Row   = 9'd5;
        Bullet_Col   = 10'd399;
        Bullet_Valid = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Bullet_Valid = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        chk("midreset_ready", 64'(Bullet_Ready), 64'd1);
        chk("midreset_hit_valid", 64'(Hit_Valid), 64'd0);
        chk("midreset_alive", 64'(Aliens_Alive), {14'd0, {50{1'b1}}});
        @(negedge Clk);
        Reset = 1'b0;
        alive_exp = '1;
        score_exp = 0;
        strobes = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge Clk);
            if (Hit_Valid === 1'b1)
                strobes++;
        end
        chk("midreset_no_strobe", 64'(strobes), 64'd0);
        chk("midreset_ready_after", 64'(Bullet_Ready), 64'd1);
`ifdef ALIEN_SCORE_EN
        chk("midreset_score", 64'(Score), 64'd0);
`endif
        run_one("after_reset", 9'd0, 10'd10, 9'd35, 10'd93, -1, 7, 1'b1, 6'd12);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
